// File: rtl/icache_assoc_pkg.sv
// Shared constants, types and the controller state encoding for icache_assoc.
// common_pkg and AXI_bus_pkg supply the machine word size and the default AXI
// read-data width. icache_assoc_pkg derives the default cache geometry from them.
// No ports. These are packages only.
package common_pkg;
  localparam int WDSZ = 32;
endpackage

package AXI_bus_pkg;
  localparam int AXI_WIDTH = 64;
endpackage

package icache_assoc_pkg;
  localparam int WDSZ          = common_pkg::WDSZ;
  localparam int DEF_AXI_WIDTH = AXI_bus_pkg::AXI_WIDTH;
  localparam int DEF_WAYS      = 2;
  localparam int DEF_LADDRSZ   = 6;
  localparam int DEF_WADDRSZ   = 4;

  localparam int TAGSZ       = 32 - DEF_LADDRSZ - DEF_WADDRSZ - 2;
  localparam int LNUM        = 1 << DEF_LADDRSZ;
  localparam int WNUM        = 1 << DEF_WADDRSZ;
  localparam int LINEBITS    = WNUM * WDSZ;
  localparam int ALLOC_BEATS = LINEBITS / DEF_AXI_WIDTH;

  typedef logic [TAGSZ-1:0]       tag_t;
  typedef logic [DEF_LADDRSZ-1:0] laddr_t;
  typedef logic [DEF_WADDRSZ-1:0] waddr_t;
  typedef logic [LINEBITS-1:0]    line_t;

  typedef struct packed {
    tag_t       tag;
    laddr_t     set;
    waddr_t     word;
    logic [1:0] byte_off;
  } addr_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_AR,
    REFILL,
    RESP
  } state_t;
endpackage

// File: rtl/icache_way_mem.sv
// Tag and data storage for one way of icache_assoc.
// The read port is synchronous: the tag and line appear on the clock after rd_en.
// The write port writes one tag and one full line per cycle.
// Ports:
//   clk              clock
//   rd_en, rd_set    read request for one set
//   rd_tag, rd_line  registered read data
//   wr_en, wr_set    write request for one set
//   wr_tag, wr_line  data to write
module icache_way_mem #(
  parameter int TAG_BITS  = 20,
  parameter int SET_BITS  = 6,
  parameter int LINE_BITS = 512
) (
  input  logic                 clk,
  input  logic                 rd_en,
  input  logic [SET_BITS-1:0]  rd_set,
  output logic [TAG_BITS-1:0]  rd_tag,
  output logic [LINE_BITS-1:0] rd_line,
  input  logic                 wr_en,
  input  logic [SET_BITS-1:0]  wr_set,
  input  logic [TAG_BITS-1:0]  wr_tag,
  input  logic [LINE_BITS-1:0] wr_line
);

  logic [TAG_BITS-1:0]  tag_ram  [1 << SET_BITS];
  logic [LINE_BITS-1:0] data_ram [1 << SET_BITS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_ram[wr_set]  <= wr_tag;
      data_ram[wr_set] <= wr_line;
    end
    if (rd_en) begin
      rd_tag  <= tag_ram[rd_set];
      rd_line <= data_ram[rd_set];
    end
  end

endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative read-only instruction cache. A miss refills one whole
// line with a single AXI INCR burst.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   req_valid/req_ready/req_addr      fetch request (byte address)
//   resp_valid/resp_data/resp_err     one-cycle fetch response
//   flush                             invalidate every line
//   ar*                               AXI read address channel
//   rdata/rresp/rlast/rvalid/rready   AXI read data channel
//   perf_hits, perf_misses            lookup counters
// Optional feature: defining ICACHE_PERF_EN builds the hit and miss counters.
// Without it, both perf outputs are tied to 0.
//
// state   | meaning
// IDLE    | ready for a request; the set RAMs are read when one is accepted
// LOOKUP  | compare all ways; a hit responds and can accept the next request
// MISS_AR | present the line address on AR until arready
// REFILL  | collect R beats into the line buffer
// RESP    | install the line (unless an error occurred) and respond
module icache_assoc import icache_assoc_pkg::*; #(
  parameter int WAYS      = DEF_WAYS,
  parameter int LADDRSZ   = DEF_LADDRSZ,
  parameter int WADDRSZ   = DEF_WADDRSZ,
  parameter int AXI_WIDTH = DEF_AXI_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_addr,
  output logic                 resp_valid,
  output logic [31:0]          resp_data,
  output logic                 resp_err,
  input  logic                 flush,
  output logic [31:0]          araddr,
  output logic [7:0]           arlen,
  output logic [2:0]           arsize,
  output logic [1:0]           arburst,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [AXI_WIDTH-1:0] rdata,
  input  logic [1:0]           rresp,
  input  logic                 rlast,
  input  logic                 rvalid,
  output logic                 rready,
  output logic [31:0]          perf_hits,
  output logic [31:0]          perf_misses
);

  localparam int TAG_BITS  = 32 - LADDRSZ - WADDRSZ - 2;
  localparam int SET_NUM   = 1 << LADDRSZ;
  localparam int WORD_NUM  = 1 << WADDRSZ;
  localparam int LINE_BITS = WORD_NUM * WDSZ;
  localparam int BEATS     = LINE_BITS / AXI_WIDTH;
  localparam int WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int BEAT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t                state;
  logic [TAG_BITS-1:0]   lk_tag;
  logic [LADDRSZ-1:0]    lk_set;
  logic [WADDRSZ-1:0]    lk_word;
  logic [WAYS-1:0]       valid [SET_NUM];
  logic [WAY_BITS-1:0]   rr    [SET_NUM];
  logic [WAY_BITS-1:0]   victim;
  logic                  victim_rr;
  logic [BEAT_BITS-1:0]  beat;
  logic [LINE_BITS-1:0]  line_buf;
  logic                  err_flag;
  logic                  flush_pend;
  logic [31:0]           miss_addr;

  logic [TAG_BITS-1:0]   way_tag  [WAYS];
  logic [LINE_BITS-1:0]  way_line [WAYS];
  logic [WAYS-1:0]       hit_vec;
  logic [LINE_BITS-1:0]  hit_line;
  logic                  lk_hit;
  logic                  do_flush;
  logic                  accept;
  logic                  install;
  logic [LADDRSZ-1:0]    req_set;
  logic [WAY_BITS-1:0]   vict_c;
  logic                  vict_rr_c;
  logic [WAY_BITS-1:0]   rr_next;
  logic                  unused_addr_bits;

  assign req_set          = req_addr[LADDRSZ+WADDRSZ+1 : WADDRSZ+2];
  assign unused_addr_bits = ^req_addr[1:0];

  // Exactly one way can match, so OR-ing the matching lines selects it.
  always_comb begin
    hit_vec  = '0;
    hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[lk_set][w] && (way_tag[w] == lk_tag)) begin
        hit_vec[w] = 1'b1;
        hit_line   = hit_line | way_line[w];
      end
    end
  end

  // The lowest invalid way wins. If every way is valid, use the round-robin pointer.
  always_comb begin
    vict_c    = rr[lk_set];
    vict_rr_c = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[lk_set][w]) begin
        vict_c    = WAY_BITS'(w);
        vict_rr_c = 1'b0;
      end
    end
  end

  assign rr_next  = (int'(rr[lk_set]) == WAYS - 1) ? '0 : rr[lk_set] + 1'b1;

  assign lk_hit   = (state == LOOKUP) && (|hit_vec);
  // A flush latched during a refill runs in the IDLE cycle after RESP.
  assign do_flush = (flush || flush_pend) && ((state == IDLE) || (state == LOOKUP));
  assign req_ready = !rst && !do_flush && ((state == IDLE) || lk_hit);
  assign accept   = req_valid && req_ready;
  assign install  = (state == RESP) && !err_flag;

  assign resp_valid = lk_hit || (state == RESP);
  assign resp_err   = (state == RESP) && err_flag;
  assign resp_data  = lk_hit  ? hit_line[int'(lk_word)*WDSZ +: WDSZ] :
                      install ? line_buf[int'(lk_word)*WDSZ +: WDSZ] : 32'd0;

  assign araddr  = miss_addr;
  assign arlen   = 8'(BEATS - 1);
  assign arsize  = 3'($clog2(AXI_WIDTH / 8));
  assign arburst = 2'b01;
  assign arvalid = (state == MISS_AR);
  assign rready  = (state == REFILL);

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    icache_way_mem #(
      .TAG_BITS  (TAG_BITS),
      .SET_BITS  (LADDRSZ),
      .LINE_BITS (LINE_BITS)
    ) u_way (
      .clk     (clk),
      .rd_en   (accept),
      .rd_set  (req_set),
      .rd_tag  (way_tag[g]),
      .rd_line (way_line[g]),
      .wr_en   (install && (victim == WAY_BITS'(g))),
      .wr_set  (lk_set),
      .wr_tag  (lk_tag),
      .wr_line (line_buf)
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lk_tag     <= '0;
      lk_set     <= '0;
      lk_word    <= '0;
      victim     <= '0;
      victim_rr  <= 1'b0;
      beat       <= '0;
      err_flag   <= 1'b0;
      flush_pend <= 1'b0;
      miss_addr  <= '0;
      for (int i = 0; i < SET_NUM; i++) begin
        valid[i] <= '0;
        rr[i]    <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (accept) state <= LOOKUP;
        end
        LOOKUP: begin
          if (lk_hit) begin
            state <= accept ? LOOKUP : IDLE;
          end else begin
            state     <= MISS_AR;
            miss_addr <= {lk_tag, lk_set, {(WADDRSZ+2){1'b0}}};
            victim    <= vict_c;
            victim_rr <= vict_rr_c;
            err_flag  <= 1'b0;
            beat      <= '0;
          end
        end
        MISS_AR: begin
          if (arready) state <= REFILL;
        end
        REFILL: begin
          if (rvalid) begin
            line_buf[int'(beat)*AXI_WIDTH +: AXI_WIDTH] <= rdata;
            beat <= beat + 1'b1;
            if (rresp != 2'b00) err_flag <= 1'b1;
            if (rlast) state <= RESP;
          end
        end
        RESP: begin
          if (!err_flag) begin
            valid[lk_set][victim] <= 1'b1;
            if (victim_rr) rr[lk_set] <= rr_next;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        lk_tag  <= req_addr[31 : LADDRSZ+WADDRSZ+2];
        lk_set  <= req_set;
        lk_word <= req_addr[WADDRSZ+1 : 2];
      end

      if (flush && ((state == MISS_AR) || (state == REFILL) || (state == RESP)))
        flush_pend <= 1'b1;

      if (do_flush) begin
        flush_pend <= 1'b0;
        for (int i = 0; i < SET_NUM; i++) begin
          valid[i] <= '0;
          rr[i]    <= '0;
        end
      end
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (lk_hit) hit_cnt <= hit_cnt + 32'd1;
      if ((state == LOOKUP) && !lk_hit) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign perf_hits   = hit_cnt;
  assign perf_misses = miss_cnt;
`else
  assign perf_hits   = 32'd0;
  assign perf_misses = 32'd0;
`endif

endmodule

// File: tb/tb_icache_assoc.sv
module tb_icache_assoc;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        flush;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [31:0] perf_hits;
  logic [31:0] perf_misses;

  int checks = 0;
  int errors = 0;

`ifdef ICACHE_PERF_EN
  localparam logic [31:0] EXP_HITS   = 32'd3;
  localparam logic [31:0] EXP_MISSES = 32'd1;
`else
  localparam logic [31:0] EXP_HITS   = 32'd0;
  localparam logic [31:0] EXP_MISSES = 32'd0;
`endif

  icache_assoc dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_err    (resp_err),
    .flush       (flush),
    .araddr      (araddr),
    .arlen       (arlen),
    .arsize      (arsize),
    .arburst     (arburst),
    .arvalid     (arvalid),
    .arready     (arready),
    .rdata       (rdata),
    .rresp       (rresp),
    .rlast       (rlast),
    .rvalid      (rvalid),
    .rready      (rready),
    .perf_hits   (perf_hits),
    .perf_misses (perf_misses)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One fetch. A miss is served by an AXI slave whose memory holds each word's
  // own byte address. err_beat and flush_beat select a beat (-1 = none).
  task automatic fetch(input string nm, input logic [31:0] a, input bit exp_hit,
                       input int err_beat, input int flush_beat, input int ar_delay);
    logic [31:0] line_a;
    logic [31:0] word_a;
    line_a = a & 32'hFFFF_FFC0;
    word_a = a & 32'hFFFF_FFFC;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    #1 check({nm, "_ready"}, req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    if (exp_hit) begin
      check({nm, "_hit_valid"}, resp_valid, 1);
      check({nm, "_hit_data"}, resp_data, word_a);
      check({nm, "_hit_err"}, resp_err, 0);
    end else begin
      check({nm, "_miss_novalid"}, resp_valid, 0);
      @(negedge clk);
      #1;
      check({nm, "_arvalid"}, arvalid, 1);
      check({nm, "_araddr"}, araddr, line_a);
      check({nm, "_arlen"}, arlen, 8'd7);
      check({nm, "_arsize_burst"}, {arsize, arburst}, {3'd3, 2'b01});
      for (int d = 0; d < ar_delay; d++) begin
        @(negedge clk);
        #1 check({nm, "_ar_hold"}, {arvalid, araddr}, {1'b1, line_a});
      end
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      for (int i = 0; i < 8; i++) begin
        rvalid = 1'b1;
        rdata  = {line_a + 32'(8 * i) + 32'd4, line_a + 32'(8 * i)};
        rresp  = (i == err_beat) ? 2'b10 : 2'b00;
        rlast  = (i == 7);
        flush  = (i == flush_beat);
        #1 check({nm, "_rready"}, rready, 1);
        @(negedge clk);
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
      flush  = 1'b0;
      #1;
      check({nm, "_resp_valid"}, resp_valid, 1);
      check({nm, "_resp_err"}, resp_err, (err_beat >= 0) ? 1 : 0);
      check({nm, "_resp_data"}, resp_data, (err_beat >= 0) ? 32'd0 : word_a);
    end
  endtask

  logic [31:0] hv [3];

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
    arready = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_outs", {resp_valid, resp_err, arvalid, rready}, 0);
    check("rst_data", resp_data, 0);
    check("rst_araddr", araddr, 0);
    check("rst_perf", perf_hits | perf_misses, 0);
    @(negedge clk);
    rst = 1'b0;

    // Cold miss; AR is held one extra cycle to confirm the address stays stable.
    fetch("cold", 32'h0000_1004, 1'b0, -1, -1, 1);

    // Back-to-back hits.
    hv[0] = 32'h1000; hv[1] = 32'h1008; hv[2] = 32'h103C;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = hv[0];
    #1 check("b2b_ready0", req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i < 2) req_addr = hv[i+1];
      else req_valid = 1'b0;
      #1;
      check("b2b_valid", resp_valid, 1);
      check("b2b_data", resp_data, hv[i]);
      if (i < 2) check("b2b_ready", req_ready, 1);
    end
    @(negedge clk);
    #1 check("b2b_end", resp_valid, 0);
    check("perf_hits", perf_hits, EXP_HITS);
    check("perf_misses", perf_misses, EXP_MISSES);

    // Replacement in set 0: A=0x1000 (already in way 0), B=0x2000, C=0x3000.
    fetch("fill_b", 32'h2000, 1'b0, -1, -1, 0);
    fetch("fill_c", 32'h3000, 1'b0, -1, -1, 0);
    fetch("hit_b", 32'h2000, 1'b1, -1, -1, 0);
    fetch("miss_a", 32'h1000, 1'b0, -1, -1, 0);
    fetch("hit_c", 32'h3000, 1'b1, -1, -1, 0);
    fetch("hit_a", 32'h1010, 1'b1, -1, -1, 0);
    fetch("miss_b", 32'h2000, 1'b0, -1, -1, 0);

    // Error on beat 3: nothing is installed, so the re-read misses again.
    fetch("err", 32'h5048, 1'b0, 3, -1, 0);
    fetch("err_reread", 32'h5048, 1'b0, -1, -1, 0);
    fetch("err_hit", 32'h504C, 1'b1, -1, -1, 0);

    // Flush on beat 2: the response completes, then the flush takes one cycle.
    fetch("flush", 32'h6080, 1'b0, -1, 2, 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h6084;
    #1 check("flush_ready_low", req_ready, 0);
    fetch("flush_remiss", 32'h6084, 1'b0, -1, -1, 0);
    fetch("flush_other", 32'h504C, 1'b0, -1, -1, 0);

    // Flush in IDLE.
    @(negedge clk);
    flush = 1'b1;
    #1 check("idle_flush_ready", req_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    fetch("idle_flush_miss", 32'h6088, 1'b0, -1, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/icache_assoc.md
# icache_assoc

Parametrised N-way set-associative, read-only instruction cache between the fetch stage and the AXI read port. It is the successor to the direct-mapped icache geometry, adding:
- configurable associativity with per-set round-robin replacement;
- single-cycle hit with back-to-back throughput;
- a whole-cache flush;
- AXI error reporting.

Fetch issues word addresses. Misses refill a full line with one INCR burst.

## Interface
Parameters:
- WAYS, 2: associativity, power of two, 1..8.
- LADDRSZ, 6: set-index bits (LNUM = 2^LADDRSZ sets).
- WADDRSZ, 4: word-in-line bits (WNUM = 16 words, 64-byte line).
- AXI_WIDTH, 64: read-data width. Must be a multiple of 32 and ≤ LINEBITS. ALLOC_BEATS = WNUM*32/AXI_WIDTH.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
  - clk  in  1  clock.
  - rst  in  1  synchronous active-high reset.
- Fetch request and response:
  - req_valid  in  1  fetch request.
  - req_ready  out  1  request accepted this cycle when both high.
  - req_addr  in  32  byte address; bits [1:0] ignored.
  - resp_valid  out  1  one-cycle response pulse; no backpressure.
  - resp_data  out  32  instruction word.
  - resp_err  out  1  refill returned a nonzero rresp.
- Flush:
  - flush  in  1  invalidate all lines (pulse).
- AXI read address channel:
  - araddr  out  32  line-aligned burst address.
  - arlen  out  8  ALLOC_BEATS-1.
  - arsize  out  3  log2(AXI_WIDTH/8).
  - arburst  out  2  2'b01 (INCR).
  - arvalid  out  1.
  - arready  in  1.
- AXI read data channel:
  - rdata  in  AXI_WIDTH.
  - rresp  in  2.
  - rlast  in  1.
  - rvalid  in  1.
  - rready  out  1.
- Performance counters:
  - perf_hits  out  32  hit counter (see Configuration).
  - perf_misses  out  32  miss counter (see Configuration).

## Operation
- Address split: tag = addr[31:LADDRSZ+WADDRSZ+2], set = next LADDRSZ bits, word = next WADDRSZ bits.
- States:
  - IDLE: req_ready=1. On accept, the tag/data RAMs are read synchronously for the set → LOOKUP.
  - LOOKUP: compare all ways. A hit requires valid && tag match; exactly one way hits.
    - Hit: resp_valid=1 with the selected word. req_ready=1, so a new request is accepted the same cycle (stay in LOOKUP if accepted, else IDLE).
    - Miss: → MISS_AR; req_ready=0.
  - MISS_AR: arvalid=1, araddr = {tag,set,0}, held stable until arready → REFILL.
  - REFILL: rready=1. Beat i writes words i*(AXI_WIDTH/32) onward into the line buffer, lower word first. Any nonzero rresp sets an error flag. The rlast beat → RESP.
  - RESP: one cycle.
    - Success: the line is written to the victim way with valid=1, and resp_data is the requested word from the buffer.
    - Error: no install; resp_err=1, resp_data=0. The round-robin pointer is unchanged.
    - → IDLE.
- Victim selection: lowest-index invalid way. If all ways are valid, the per-set round-robin pointer is used and then incremented modulo WAYS.
- Flush:
  - In IDLE, or in LOOKUP without an accept: all valid bits clear at the next edge, and req_ready=0 that cycle.
  - In MISS_AR, REFILL or RESP: the flush is latched pending. The refill completes and responds normally. The flush then executes in the cycle after RESP, before any new accept.
  - Round-robin pointers also reset on flush.
- resp_err is cleared on every non-error response.

## Timing
- Hit: request accepted at edge N; resp_valid in cycle N+1. Sustained rate is one request per cycle on consecutive hits.
- Miss:
  - arvalid rises in cycle N+2.
  - The response arrives in the cycle after the rlast handshake.
  - Minimum latency = 3 + ALLOC_BEATS cycles with zero-wait AXI.
- Reset values:
  - state IDLE, all valid bits 0, round-robin pointers 0, pending flush 0.
  - req_ready=0 during reset.
  - resp_valid, resp_err, arvalid, rready = 0; resp_data = 0; araddr = 0.
  - perf counters 0.
- Reset mid-refill: abandons the burst. Remaining R beats after reset are accepted only if rready is high; the cache keeps rready=0, and the interconnect reset is required to clear the burst.
- A refill to a set already holding that tag cannot occur, because a miss implies absence.

## Configuration
- ICACHE_PERF_EN defined:
  - perf_hits increments on each LOOKUP hit.
  - perf_misses increments on each LOOKUP miss.
  - Both are 32-bit, wrap on overflow, and clear on rst and not on flush.
- ICACHE_PERF_EN undefined: perf_hits and perf_misses are tied to 0, no counter logic is synthesised, and the ports remain.

## Structure
- Package icache_assoc_pkg holds:
  - derived constants: TAGSZ, LNUM, WNUM, LINEBITS, ALLOC_BEATS;
  - typedefs: tag_t, laddr_t, waddr_t, addr_t packed struct, line_t;
  - the state enum {IDLE, LOOKUP, MISS_AR, REFILL, RESP}.
- It imports WDSZ from common_pkg and AXI_WIDTH from AXI_bus_pkg as defaults.
- Sub-module icache_way_mem: one way's synchronous tag+data RAM, with one read port and one full-line write port. It is instantiated WAYS times.
- Valid bits and round-robin pointers live in flops in the top level, for single-cycle flush.

## Test plan
- Cold miss: read 0x0000_1004, AXI returns 8 beats with word k = 0x1000+4k. Require:
  - arlen=7, araddr=0x1000;
  - resp_data=0x1004 in the cycle after rlast.
- Back-to-back hits: read 0x1000, 0x1008, 0x103C after the fill. Require 3 consecutive resp_valid cycles with data 0x1000, 0x1008, 0x103C.
- Replacement (WAYS=2): fill tags A, B, C in set 0. Require:
  - C evicts A;
  - re-reading B hits;
  - re-reading A misses and evicts B.
- Error: rresp=2'b10 on beat 3. Require resp_err=1, resp_data=0, and a re-read of the same address misses again.
- Flush during REFILL: assert flush on beat 2. Require:
  - the response is still correct;
  - the next request to the same line misses;
  - req_ready=0 for the one flush cycle.
- ICACHE_PERF_EN: after the cold-miss and hit scenarios, require perf_hits=3 and perf_misses=1. With the macro undefined, both are 0.
